// File: rtl/counter_bank_pkg.sv
// Shared types and helpers for the counter bank: FSM state encoding and channel-index sizing.
package counter_bank_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // A single-channel bank still needs a 1-bit index port.
    function automatic int ch_idx_w(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/counter_bank_chan.sv
// One W-bit counter with clear > load > increment priority and overflow pulse.
// COUNTER_BANK_SAT_EN selects saturating increments instead of modulo wrap.
module counter_bank_chan #(
    parameter int W    = 4,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_value,
    input  logic         i_en,
    output logic [W-1:0] o_value,
    output logic [W-1:0] o_next,
    output logic         o_wrap
);

    logic [W-1:0] r_value;
    logic         r_wrap;
    logic [W:0]   w_sum;
    logic [W-1:0] w_next;
    logic         w_wrap_next;

    assign w_sum = {1'b0, r_value} + (W+1)'(STEP);

`ifdef COUNTER_BANK_SAT_EN
    // Set by the first overflowing increment so later ones at full scale stay silent.
    logic r_sat;
    logic w_sat_next;

    always_comb begin
        w_next      = r_value;
        w_wrap_next = 1'b0;
        w_sat_next  = r_sat;
        if (i_clr) begin
            w_next     = '0;
            w_sat_next = 1'b0;
        end else if (i_load) begin
            w_next     = i_load_value;
            w_sat_next = 1'b0;
        end else if (i_en) begin
            if (w_sum[W]) begin
                w_next      = '1;
                w_wrap_next = ~r_sat;
                w_sat_next  = 1'b1;
            end else begin
                w_next = w_sum[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sat <= 1'b0;
        else        r_sat <= w_sat_next;
    end
`else
    always_comb begin
        w_next      = r_value;
        w_wrap_next = 1'b0;
        if (i_clr) begin
            w_next = '0;
        end else if (i_load) begin
            w_next = i_load_value;
        end else if (i_en) begin
            w_next      = w_sum[W-1:0];
            w_wrap_next = w_sum[W];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_value <= w_next;
            r_wrap  <= w_wrap_next;
        end
    end

    assign o_value = r_value;
    assign o_next  = w_next;
    assign o_wrap  = r_wrap;

endmodule

// File: rtl/counter_bank.sv
// Bank of NCH up-counters with load handshake, registered readout and a sequenced clear sweep.
// Define COUNTER_BANK_SAT_EN for saturating counters (see counter_bank_chan).
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter  int W    = 4,
    parameter  int NCH  = 4,
    parameter  int STEP = 1,
    localparam int CHW  = ch_idx_w(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   i_en,
    input  logic             i_load_valid,
    output logic             i_load_ready,
    input  logic [CHW-1:0]   i_load_ch,
    input  logic [W-1:0]     i_load_value,
    input  logic             i_clr,
    input  logic             i_rd_req,
    input  logic [CHW-1:0]   i_rd_ch,
    output logic             o_rd_valid,
    output logic [W-1:0]     o_rd_data,
    output logic [NCH*W-1:0] o_value,
    output logic [NCH-1:0]   o_wrap,
    output logic             o_busy
);

    state_e         r_state;
    state_e         w_state_nxt;
    logic [CHW-1:0] r_idx;
    logic [CHW-1:0] w_idx_nxt;

    logic           w_load_acc;
    logic [W-1:0]   w_next [NCH];
    logic           w_rd_in_range;
    logic           r_rd_valid;
    logic [W-1:0]   r_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (i_clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (r_idx == CHW'(NCH - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + CHW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (r_state == ST_CLEAR);
        i_load_ready = (r_state == ST_IDLE);
    end

    // Out-of-range load channels complete the handshake but match no counter.
    assign w_load_acc = i_load_valid && i_load_ready;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        logic w_clr_c;
        logic w_load_c;

        assign w_clr_c  = o_busy && (r_idx == CHW'(c));
        assign w_load_c = w_load_acc && (i_load_ch == CHW'(c));

        counter_bank_chan #(
            .W    (W),
            .STEP (STEP)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_clr        (w_clr_c),
            .i_load       (w_load_c),
            .i_load_value (i_load_value),
            .i_en         (i_en[c]),
            .o_value      (o_value[c*W +: W]),
            .o_next       (w_next[c]),
            .o_wrap       (o_wrap[c])
        );
    end

    // Readout captures the post-update value so data matches o_value in the valid cycle.
    assign w_rd_in_range = ({1'b0, i_rd_ch} < (CHW+1)'(NCH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= i_rd_req;
            if (i_rd_req) r_rd_data <= w_rd_in_range ? w_next[i_rd_ch] : '0;
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;

endmodule

// File: tb/tb_counter_bank.sv
// Scoreboard bench for counter_bank: directed scenarios plus random traffic vs. a reference model.
module tb_counter_bank;

    localparam int W    = 4;
    localparam int NCH  = 4;
    localparam int STEP = 1;
    localparam int CHW  = 2;
    localparam int MAXV = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   i_en;
    logic             i_load_valid;
    logic             i_load_ready;
    logic [CHW-1:0]   i_load_ch;
    logic [W-1:0]     i_load_value;
    logic             i_clr;
    logic             i_rd_req;
    logic [CHW-1:0]   i_rd_ch;
    logic             o_rd_valid;
    logic [W-1:0]     o_rd_data;
    logic [NCH*W-1:0] o_value;
    logic [NCH-1:0]   o_wrap;
    logic             o_busy;

    always #5 clk = ~clk;

    counter_bank #(.W(W), .NCH(NCH), .STEP(STEP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (i_en),
        .i_load_valid (i_load_valid),
        .i_load_ready (i_load_ready),
        .i_load_ch    (i_load_ch),
        .i_load_value (i_load_value),
        .i_clr        (i_clr),
        .i_rd_req     (i_rd_req),
        .i_rd_ch      (i_rd_ch),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data),
        .o_value      (o_value),
        .o_wrap       (o_wrap),
        .o_busy       (o_busy)
    );

    int m_val  [NCH];
    bit m_sat  [NCH];
    bit m_wrap [NCH];
    bit m_sweep;
    int m_sweep_pos;
    int exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_val[c]  = 0;
            m_sat[c]  = 0;
            m_wrap[c] = 0;
        end
        m_sweep     = 0;
        m_sweep_pos = 0;
        exp_q.delete();
    endfunction

    function automatic int chan_val(input int c);
        return int'(o_value[c*W +: W]);
    endfunction

    task automatic check_outputs();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("value[%0d]", c), chan_val(c), m_val[c]);
            chk($sformatf("wrap[%0d]", c), int'(o_wrap[c]), int'(m_wrap[c]));
        end
        chk("busy", int'(o_busy), int'(m_sweep));
        chk("load_ready", int'(i_load_ready), int'(!m_sweep));
    endtask

    // Called at a falling edge: check state, drive one cycle of stimulus, predict, advance.
    task automatic cycle(input logic [NCH-1:0] en, input bit lv, input int lch, input int lval,
                         input bit clr, input bit rd, input int rdch);
        bit accepted;
        int sum;
        check_outputs();
        i_en         = en;
        i_load_valid = lv;
        i_load_ch    = CHW'(lch);
        i_load_value = W'(lval);
        i_clr        = clr;
        i_rd_req     = rd;
        i_rd_ch      = CHW'(rdch);

        accepted = lv && !m_sweep;
        for (int c = 0; c < NCH; c++) begin
            m_wrap[c] = 0;
            if (m_sweep && m_sweep_pos == c) begin
                m_val[c] = 0;
                m_sat[c] = 0;
            end else if (accepted && lch == c) begin
                m_val[c] = lval;
                m_sat[c] = 0;
            end else if (en[c]) begin
                sum = m_val[c] + STEP;
`ifdef COUNTER_BANK_SAT_EN
                if (sum > MAXV) begin
                    m_wrap[c] = !m_sat[c];
                    m_sat[c]  = 1;
                    m_val[c]  = MAXV;
                end else begin
                    m_val[c] = sum;
                end
`else
                m_wrap[c] = (sum > MAXV);
                m_val[c]  = sum % (MAXV + 1);
`endif
            end
        end
        if (m_sweep) begin
            if (m_sweep_pos == NCH - 1) m_sweep = 0;
            else m_sweep_pos++;
        end else if (clr) begin
            m_sweep     = 1;
            m_sweep_pos = 0;
        end
        if (rd) exp_q.push_back((rdch < NCH) ? m_val[rdch] : 0);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle('0, 0, 0, 0, 0, 0, 0);
    endtask

    // Readout monitor: every valid must match the oldest prediction, and none may be skipped.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (o_rd_valid) begin
                if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_data", int'(o_rd_data), exp_q.pop_front());
            end else if (exp_q.size() != 0) begin
                chk("rd_missing", 0, 1);
                exp_q.delete();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int seq_exp [3];

    initial begin
        rst_n = 1'b0;
        i_en = '0; i_load_valid = 0; i_load_ch = '0; i_load_value = '0;
        i_clr = 0; i_rd_req = 0; i_rd_ch = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Wrap / saturation on channel 2 from 0xE.
        cycle('0, 1, 2, 14, 0, 0, 0);
`ifdef COUNTER_BANK_SAT_EN
        seq_exp = '{15, 15, 15};
`else
        seq_exp = '{15, 0, 1};
`endif
        for (int k = 0; k < 3; k++) begin
            cycle(4'b0100, 0, 0, 0, 0, 1, 2);
            chk("wrap_seq", chan_val(2), seq_exp[k]);
            chk("wrap_pulse", int'(o_wrap[2]), (k == 1) ? 1 : 0);
        end
        cycle('0, 1, 2, 0, 0, 0, 0);
        cycle(4'b0100, 0, 0, 0, 0, 0, 0);
        chk("resume_after_load", chan_val(2), 1);

        // Load beats same-cycle increment.
        cycle('0, 1, 1, 5, 0, 0, 0);
        cycle(4'b0010, 1, 1, 9, 0, 0, 0);
        chk("load_over_inc", chan_val(1), 9);
        cycle(4'b0010, 0, 0, 0, 0, 0, 0);
        chk("inc_after_load", chan_val(1), 10);
        chk("no_wrap_load", int'(o_wrap[1]), 0);

        // Clear sweep with all channels counting; a second i_clr and loads are ignored.
        cycle('1, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < NCH; k++) begin
            chk("sweep_busy", int'(o_busy), 1);
            chk("sweep_ready", int'(i_load_ready), 0);
            cycle('1, 1, k, 7, (k == 1), 1, k);
            chk("sweep_zero", chan_val(k), 0);
        end
        chk("sweep_done", int'(o_busy), 0);
        chk("sweep_ready_back", int'(i_load_ready), 1);

        // Pipelined readout of channel 3 while it counts.
        cycle('0, 1, 3, 3, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(4'b1000, 0, 0, 0, 0, 1, 3);
        idle();
        chk("rd_burst_end", chan_val(3), 6);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            cycle(NCH'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, NCH - 1),
                  $urandom_range(0, MAXV), ($urandom_range(0, 24) == 0),
                  $urandom_range(0, 1) == 1, $urandom_range(0, NCH - 1));
        end

        // Asynchronous reset in the middle of a sweep.
        cycle('1, 0, 0, 0, 1, 1, 0);
        cycle('1, 0, 0, 0, 0, 1, 1);
        i_en = '0; i_clr = 0; i_rd_req = 0; i_load_valid = 0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_value", int'(o_value), 0);
        chk("rst_wrap", int'(o_wrap), 0);
        chk("rst_rd_valid", int'(o_rd_valid), 0);
        chk("rst_rd_data", int'(o_rd_data), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_ready", int'(i_load_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();
        chk("post_rst_value", int'(o_value), 0);

        for (int n = 0; n < 200; n++) begin
            cycle(NCH'($urandom), ($urandom_range(0, 2) == 0), $urandom_range(0, NCH - 1),
                  $urandom_range(0, MAXV), ($urandom_range(0, 15) == 0),
                  $urandom_range(0, 1) == 1, $urandom_range(0, NCH - 1));
        end
        repeat (3) idle();
        chk("rd_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
